// File: rtl/cnn_frame_feeder.sv
// cnn_frame_feeder: ping-pong frame buffer between a camera stream and CNN_TOP.
// Captures raster frames from a gappy camera interface into one of two banks,
// then replays each complete frame as a start pulse followed by IMG_W*IMG_H
// contiguous pixel beats, holding the next frame until CNN_TOP reports done.
// Optional feature: define FRAME_DROP_EN to drop frames instead of applying
// backpressure when no bank is free.
module cnn_frame_feeder #(
    parameter int unsigned IMG_W     = 32,
    parameter int unsigned IMG_H     = 32,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned START_GAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cam_valid,
    input  logic             cam_sof,
    input  logic [PIX_W-1:0] cam_pixel,
    output logic             cam_ready,
    output logic             cnn_start,
    output logic             cnn_pixel_valid,
    output logic [PIX_W-1:0] cnn_pixel,
    input  logic             cnn_result_valid,
    output logic [15:0]      frames_sent,
    output logic [7:0]       sof_err_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned AW = $clog2(N + 1);
    localparam int unsigned MW = $clog2(2 * N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0] N_ADDR    = AW'(N);
    localparam logic [2:0]    GAP_LAST  = 3'((START_GAP > 0) ? START_GAP - 1 : 0);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_GAP, R_STREAM, R_WAIT} rstate_t;

    logic [PIX_W-1:0] mem [2*N];

    logic [1:0]    full;      // bank holds a complete frame not yet taken by the reader
    logic          older;     // which FULL bank completed first when both are FULL
    wstate_t       w_state;
    logic          w_bank;
    logic [AW-1:0] w_addr;
    rstate_t       r_state;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;   // next address to fetch (one ahead of the beat on the output)
    logic [2:0]    gap_cnt;

    logic [1:0]    empty;
    logic          have_empty;
    logic          free_bank;
    logic          accept;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          wr_complete;
    logic          sof_restart;
    logic          take;
    logic          take_bank;
    logic [MW-1:0] wr_idx;
    logic [MW-1:0] rd_idx;
`ifdef FRAME_DROP_EN
    logic          frame_drop;
`endif

    // Bank availability: not FULL, not being read, not being filled
    always_comb begin
        empty = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            empty[b] = !full[b]
                     && !((r_state != R_IDLE) && (rd_bank == 1'(b)))
                     && !((w_state == W_FILL) && (w_bank == 1'(b)));
        end
    end

    assign have_empty = |empty;
    assign free_bank  = !empty[0];

`ifdef FRAME_DROP_EN
    assign cam_ready = 1'b1;
`else
    assign cam_ready = !((w_state == W_IDLE) && !have_empty);
`endif

    assign accept = cam_valid && cam_ready;

    // Decode the camera beat into a RAM write and write-side events
    always_comb begin
        wr_en       = 1'b0;
        wr_bank     = w_bank;
        wr_addr     = w_addr;
        sof_restart = 1'b0;
`ifdef FRAME_DROP_EN
        frame_drop  = 1'b0;
`endif
        if (accept) begin
            if (w_state == W_FILL) begin
                wr_en = 1'b1;
                if (cam_sof) begin
                    wr_addr     = '0;
                    sof_restart = 1'b1;
                end
            end else if (cam_sof) begin
                if (have_empty) begin
                    wr_en   = 1'b1;
                    wr_bank = free_bank;
                    wr_addr = '0;
                end else begin
`ifdef FRAME_DROP_EN
                    frame_drop = 1'b1;
`endif
                end
            end
        end
    end

    assign wr_complete = wr_en && (wr_addr == LAST_ADDR);
    assign wr_idx = wr_bank ? (MW'(N) + MW'(wr_addr)) : MW'(wr_addr);
    assign rd_idx = rd_bank ? (MW'(N) + MW'(rd_addr)) : MW'(rd_addr);

    // Reader picks the oldest FULL bank while idle
    always_comb begin
        take      = (r_state == R_IDLE) && (|full);
        take_bank = 1'b0;
        if (full[0] && full[1]) take_bank = older;
        else if (full[1])       take_bank = 1'b1;
    end

    // Frame storage, both banks in one array
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= cam_pixel;
    end

    // FULL flags and completion order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= '0;
            older <= 1'b0;
        end else begin
            if (take) full[take_bank] <= 1'b0;
            if (wr_complete) begin
                full[wr_bank] <= 1'b1;
                older <= (full[~wr_bank] && !(take && (take_bank == ~wr_bank))) ? ~wr_bank : wr_bank;
            end
        end
    end

    // Write FSM: frame capture, SOF restart and error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state     <= W_IDLE;
            w_bank      <= 1'b0;
            w_addr      <= '0;
            sof_err_cnt <= '0;
`ifdef FRAME_DROP_EN
            drop_cnt    <= '0;
`endif
        end else begin
            if (wr_en) begin
                w_bank <= wr_bank;
                if (wr_complete) begin
                    w_state <= W_IDLE;
                    w_addr  <= '0;
                end else begin
                    w_state <= W_FILL;
                    w_addr  <= wr_addr + 1'b1;
                end
            end
            if (sof_restart && (sof_err_cnt != '1)) sof_err_cnt <= sof_err_cnt + 1'b1;
`ifdef FRAME_DROP_EN
            if (frame_drop) begin
                w_state <= W_DROP;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
`endif
        end
    end

`ifndef FRAME_DROP_EN
    assign drop_cnt = '0;
`endif

    // Read FSM: start pulse, optional gap, gap-free stream, wait for result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= R_IDLE;
            rd_bank         <= 1'b0;
            rd_addr         <= '0;
            gap_cnt         <= '0;
            cnn_start       <= 1'b0;
            cnn_pixel_valid <= 1'b0;
            cnn_pixel       <= '0;
            frames_sent     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (take) begin
                        rd_bank   <= take_bank;
                        rd_addr   <= '0;
                        cnn_start <= 1'b1;
                        r_state   <= R_START;
                    end
                end
                R_START: begin
                    cnn_start <= 1'b0;
                    if (START_GAP == 0) begin
                        cnn_pixel_valid <= 1'b1;
                        cnn_pixel       <= mem[rd_idx];
                        rd_addr         <= rd_addr + 1'b1;
                        r_state         <= R_STREAM;
                    end else begin
                        gap_cnt <= '0;
                        r_state <= R_GAP;
                    end
                end
                R_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        cnn_pixel_valid <= 1'b1;
                        cnn_pixel       <= mem[rd_idx];
                        rd_addr         <= rd_addr + 1'b1;
                        r_state         <= R_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                R_STREAM: begin
                    if (rd_addr == N_ADDR) begin
                        cnn_pixel_valid <= 1'b0;
                        cnn_pixel       <= '0;
                        frames_sent     <= frames_sent + 1'b1;
                        r_state         <= R_WAIT;
                    end else begin
                        cnn_pixel <= mem[rd_idx];
                        rd_addr   <= rd_addr + 1'b1;
                    end
                end
                R_WAIT: begin
                    if (cnn_result_valid) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
